multicycle_control: RTL and testbench

- Multi-cycle sequencer for the RV32 datapath subset: R-type, I-type ALU (addi etc.), lw, sw and beq.
- Steps one instruction through FETCH/DECODE/EXECUTE/MEM/WB over 3–5+ cycles, driving the shared ALU, register file, IR/PC write enables and a single unified memory port.
- The memory port uses a req/ready handshake.
- Counts retired instructions and traps on illegal opcodes or memory timeout.

---
 rtl/multicycle_control.sv | 148 ++++++++++++++
 tb/tb_multicycle_control.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/MEM/WB sequencer for a multi-cycle RV32 subset datapath
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       OPcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALUOp_out,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    FETCH, DECODE, ADDR, MEM_RD, MEM_WR, LOAD_WB, EXEC_R, EXEC_I, ALU_WB, BRANCH, TRAP
  } state_t;
  localparam logic [15:0] TLIM = 16'(MEM_TIMEOUT - 1);
  state_t state, state_n;
  logic [6:0]  opc;
  logic [15:0] tcnt;
  logic        tout, retire, set_ill, set_be;
  // the stalled cycle that would bring the count to MEM_TIMEOUT is the last one allowed
  assign tout = (tcnt == TLIM) && !mem_ready;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= FETCH;
      opc     <= '0;
      tcnt    <= '0;
      retired <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DECODE) opc <= OPcode;
      if (state_n != state || mem_ready) tcnt <= '0;
      else if (mem_req) tcnt <= tcnt + 16'd1;
      if (retire) retired <= retired + CNT_W'(1);
      if (set_ill) illegal <= 1'b1;
      if (set_be) bus_err <= 1'b1;
    end
  always_comb begin
    state_n       = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ALUOp_out     = 2'b00;
    RegWrite      = 1'b0;
    MemtoReg      = 1'b0;
    retire        = 1'b0;
    set_ill       = 1'b0;
    set_be        = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        set_be    = tout;
        state_n   = mem_ready ? DECODE : tout ? TRAP : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b10;
        case (OPcode)
          7'b0000011, 7'b0100011: state_n = ADDR;
          7'b0110011:             state_n = EXEC_R;
          7'b0010011:             state_n = EXEC_I;
          7'b1100011:             state_n = BRANCH;
          default: begin
            state_n = TRAP;
            set_ill = 1'b1;
          end
        endcase
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_n   = (opc == 7'b0000011) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        set_be  = tout;
        state_n = mem_ready ? LOAD_WB : tout ? TRAP : MEM_RD;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        set_be  = tout;
        retire  = mem_ready;
        state_n = mem_ready ? FETCH : tout ? TRAP : MEM_WR;
      end
      LOAD_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_n  = FETCH;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        ALUOp_out = 2'b10;
        state_n   = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ALUOp_out = 2'b10;
        state_n   = ALU_WB;
      end
      ALU_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_n  = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        ALUOp_out     = 2'b01;
        pc_write_cond = 1'b1;
        retire        = 1'b1;
        state_n       = FETCH;
      end
      default: state_n = state;
    endcase
    // reset holds the state at FETCH, so its request must be masked here
    if (!reset) begin
      mem_req  = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      alu_src_b = 2'b00;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle expected control vectors queued by stimulus, checked by a negedge monitor
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        reset, mem_ready;
  logic [6:0]  op;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, alu_src_a;
  logic [1:0]  alu_src_b, ALUOp_out;
  logic        RegWrite, MemtoReg, illegal, bus_err;
  logic [31:0] retired;
  logic [14:0] ctl;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .OPcode(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ALUOp_out(ALUOp_out), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  assign ctl = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, alu_src_a,
                alu_src_b, ALUOp_out, RegWrite, MemtoReg, illegal, bus_err};

  // req we iord | irw pcw pcc | srca srcb aluop | rw m2r | ill berr
  localparam logic [14:0] Z   = 15'b000_000_0_00_00_00_00;
  localparam logic [14:0] F1  = 15'b100_110_0_01_00_00_00;
  localparam logic [14:0] F0  = 15'b100_000_0_01_00_00_00;
  localparam logic [14:0] DEC = 15'b000_000_0_10_00_00_00;
  localparam logic [14:0] ADR = 15'b000_000_1_10_00_00_00;
  localparam logic [14:0] MRD = 15'b101_000_0_00_00_00_00;
  localparam logic [14:0] MWR = 15'b111_000_0_00_00_00_00;
  localparam logic [14:0] LWB = 15'b000_000_0_00_00_11_00;
  localparam logic [14:0] EXR = 15'b000_000_1_00_10_00_00;
  localparam logic [14:0] EXI = 15'b000_000_1_10_10_00_00;
  localparam logic [14:0] AWB = 15'b000_000_0_00_00_10_00;
  localparam logic [14:0] BR  = 15'b000_001_1_00_01_00_00;
  localparam logic [14:0] TI  = 15'b000_000_0_00_00_00_10;
  localparam logic [14:0] TB  = 15'b000_000_0_00_00_00_01;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct {
    logic [14:0] c;
    logic [31:0] r;
    string       n;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cyc(input logic rdy, input logic [6:0] o, input logic [14:0] c,
                     input logic [31:0] r, input string n);
    exp_t e;
    mem_ready = rdy;
    op        = o;
    e.c = c;
    e.r = r;
    e.n = n;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (ctl !== e.c || retired !== e.r) begin
        n_bad++;
        $display("FAIL %s: got ctl=%b retired=%0d, want ctl=%b retired=%0d",
                 e.n, ctl, retired, e.c, e.r);
      end
    end

  initial begin
    reset = 1'b0; mem_ready = 1'b0; op = '0;
    @(posedge clk); #1;
    cyc(1, R, Z, 0, "reset_0");
    cyc(1, R, Z, 0, "reset_1");
    reset = 1'b1;
    cyc(1, R, F1, 0, "r_fetch");
    cyc(1, R, DEC, 0, "r_decode");
    cyc(1, R, EXR, 0, "r_exec");
    cyc(1, R, AWB, 0, "r_wb");
    cyc(1, LW, F1, 1, "lw_fetch");
    cyc(1, LW, DEC, 1, "lw_decode");
    cyc(1, LW, ADR, 1, "lw_addr");
    cyc(0, LW, MRD, 1, "lw_wait1");
    cyc(0, LW, MRD, 1, "lw_wait2");
    cyc(1, LW, MRD, 1, "lw_mem");
    cyc(1, LW, LWB, 1, "lw_wb");
    cyc(1, SW, F1, 2, "sw_fetch");
    cyc(1, SW, DEC, 2, "sw_decode");
    cyc(1, SW, ADR, 2, "sw_addr");
    cyc(1, SW, MWR, 2, "sw_mem");
    cyc(1, BQ, F1, 3, "beq_fetch");
    cyc(1, BQ, DEC, 3, "beq_decode");
    cyc(1, BQ, BR, 3, "beq_branch");
    cyc(1, I, F1, 4, "addi_fetch");
    cyc(1, I, DEC, 4, "addi_decode");
    cyc(1, I, EXI, 4, "addi_exec");
    cyc(1, I, AWB, 4, "addi_wb");
    cyc(1, BAD, F1, 5, "ill_fetch");
    cyc(1, BAD, DEC, 5, "ill_decode");
    cyc(1, R, TI, 5, "ill_trap0");
    cyc(0, LW, TI, 5, "ill_trap1");
    cyc(1, SW, TI, 5, "ill_trap2");
    reset = 1'b0;
    cyc(1, R, Z, 0, "ill_reset");
    reset = 1'b1;
    cyc(0, R, F0, 0, "to_stall1");
    cyc(0, R, F0, 0, "to_stall2");
    cyc(0, R, F0, 0, "to_stall3");
    cyc(0, R, F0, 0, "to_stall4");
    cyc(1, R, TB, 0, "to_trap0");
    cyc(1, R, TB, 0, "to_trap1");
    reset = 1'b0;
    cyc(0, R, Z, 0, "to_reset");
    reset = 1'b1;
    cyc(0, R, F0, 0, "edge_stall1");
    cyc(0, R, F0, 0, "edge_stall2");
    cyc(0, R, F0, 0, "edge_stall3");
    cyc(1, R, F1, 0, "edge_ready4");
    cyc(1, R, DEC, 0, "edge_decode");
    cyc(1, R, EXR, 0, "edge_exec");
    cyc(1, R, AWB, 0, "edge_wb");
    cyc(1, SW, F1, 1, "swto_fetch");
    cyc(1, SW, DEC, 1, "swto_decode");
    cyc(1, SW, ADR, 1, "swto_addr");
    cyc(0, SW, MWR, 1, "swto_stall1");
    cyc(0, SW, MWR, 1, "swto_stall2");
    cyc(0, SW, MWR, 1, "swto_stall3");
    cyc(0, SW, MWR, 1, "swto_stall4");
    cyc(1, SW, TB, 1, "swto_trap0");
    cyc(1, SW, TB, 1, "swto_trap1");
    reset = 1'b0;
    cyc(1, R, Z, 0, "swto_reset");
    reset = 1'b1;
    cyc(1, LW, F1, 0, "ar_fetch");
    cyc(1, LW, DEC, 0, "ar_decode");
    cyc(1, LW, ADR, 0, "ar_addr");
    mem_ready = 1'b0;
    q.push_back('{MRD, 32'd0, "ar_mem"});
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || retired !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset: got mem_req=%b retired=%0d, want mem_req=0 retired=0",
               mem_req, retired);
    end
    @(posedge clk); #1;
    cyc(1, LW, Z, 0, "ar_hold");
    reset = 1'b1;
    cyc(1, R, F1, 0, "ar_refetch");
    cyc(1, R, DEC, 0, "ar_decode2");
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
